// File: rtl/rib_ex_bridge.sv
// rib_ex_bridge: turns the core's single-cycle data-memory access into a
// registered valid/ready request with an rvalid response, stalling the core
// through hold_o until the response arrives or the timeout expires.
// Ports:
//   clk, rst (async, active-low)
//   core side : req_i, we_i, addr_i, wdata_i -> rdata_o, hold_o, err_o
//   slave side: m_valid_o, m_we_o, m_addr_o, m_wdata_o <- m_ready_i,
//               m_rvalid_i, m_rdata_i
module rib_ex_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        hold_o,
  output logic        err_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [31:0] rdata_q;
  logic busy, got, expire;
  assign busy = state == REQ || state == RESP;
  // A response only counts once the request has been (or is being) accepted.
  assign got = m_rvalid_i && (state == RESP || (state == REQ && m_ready_i));
  // cnt holds cycles already spent in REQ/RESP; this cycle is the last one
  // allowed. A response arriving in that same cycle still wins.
  assign expire = TIMEOUT_CYCLES != 0 && busy && !got && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign hold_o = state == IDLE ? req_i : state != DONE;
  assign rdata_o = state == DONE ? rdata_q : 32'h0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rdata_q <= 32'h0;
      m_valid_o <= 1'b0;
      m_we_o <= 1'b0;
      m_addr_o <= 32'h0;
      m_wdata_o <= 32'h0;
      err_o <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (busy) cnt <= cnt + 1'b1;
      case (state)
        IDLE: if (req_i) begin
          state <= REQ;
          cnt <= '0;
          m_valid_o <= 1'b1;
          m_we_o <= we_i;
          m_addr_o <= addr_i;
          m_wdata_o <= wdata_i;
        end
        REQ, RESP: begin
          if (m_ready_i) m_valid_o <= 1'b0;
          if (got || expire) begin
            m_valid_o <= 1'b0;
            rdata_q <= got ? m_rdata_i : 32'h0;
            // A core that has withdrawn its request gets no DONE cycle and no error.
            err_o <= expire && req_i;
            state <= req_i ? DONE : IDLE;
          end else if (state == REQ && m_ready_i) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rib_ex_bridge.sv
// tb_rib_ex_bridge: directed and randomized transactions against a
// cycle-count reference of the bridge's access timing and outcome.
module tb_rib_ex_bridge;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b0;
  logic req_i = 1'b0, we_i = 1'b0, m_ready_i = 1'b0, m_rvalid_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0, m_rdata_i = '0;
  logic [31:0] rdata_o, m_addr_o, m_wdata_o;
  logic hold_o, err_o, m_valid_o, m_we_o;
  int pass_cnt = 0, total = 0;
  rib_ex_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .hold_o(hold_o), .err_o(err_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_we_o(m_we_o),
    .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) pass_cnt++;
    else $error("FAIL %s got %h exp %h", tag, o, e);
  endtask
  // One core access starting at a negedge in IDLE. Cycle 0 is the request
  // cycle; the slave raises ready dr cycles after valid and rvalid dv cycles
  // after that. mode 0: responds, 1: never ready, 2: ready but no rvalid.
  // Reference: a response completes in cycle dr+dv+2, a silent slave times
  // out with DONE in cycle TO+1; hold is high in every cycle before DONE.
  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rv, input int dr, input int dv, input int mode);
    int lat, rdy;
    lat = mode == 0 ? dr + dv + 2 : TO + 1;
    rdy = mode == 1 ? 1000 : 1 + dr;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d; m_rdata_i = rv;
    for (int i = 0; i <= lat; i++) begin
      m_ready_i = mode != 1 && i == rdy;
      m_rvalid_i = mode == 0 && i == rdy + dv;
      #1;
      chk("hold", hold_o, i < lat);
      chk("valid", m_valid_o, i >= 1 && i <= rdy && i < lat);
      chk("err", err_o, i == lat && mode != 0);
      chk("rdata", rdata_o, i == lat && mode == 0 ? rv : 32'h0);
      if (i >= 1 && i <= rdy && i < lat) begin
        chk("m_addr", m_addr_o, a);
        chk("m_we", m_we_o, we);
        chk("m_wdata", m_wdata_o, d);
      end
      @(negedge clk);
    end
    m_ready_i = 1'b0; m_rvalid_i = 1'b0;
    #1;
    chk("err_after", err_o, 0);
    chk("rdata_after", rdata_o, 0);
    if (mode != 0) begin
      req_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hBAD0BAD0;
      @(negedge clk);
      m_rvalid_i = 1'b0;
      #1;
      chk("late_hold", hold_o, 0);
      chk("late_valid", m_valid_o, 0);
      chk("late_err", err_o, 0);
      chk("late_rdata", rdata_o, 0);
    end
  endtask
  task automatic idle(input int n);
    req_i = 1'b0; m_ready_i = 1'b0; m_rvalid_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int dr, dv, md;
    #1;
    chk("rst_valid", m_valid_o, 0);
    chk("rst_we", m_we_o, 0);
    chk("rst_addr", m_addr_o, 0);
    chk("rst_wdata", m_wdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_hold", hold_o, 0);
    chk("rst_rdata", rdata_o, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    xfer(1'b0, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 0, 1, 0);
    idle(1);
    xfer(1'b1, 32'h1000_0004, 32'h55, 32'h0, 3, 2, 0);
    idle(2);
    xfer(1'b0, 32'h0, 32'h0, 32'h1111_2222, 0, 0, 0);
    xfer(1'b0, 32'h4, 32'h0, 32'h3333_4444, 0, 0, 0);
    idle(1);
    xfer(1'b0, 32'h2000_0000, 32'h0, 32'h7777_7777, 0, 0, 1);
    idle(1);
    xfer(1'b1, 32'h2000_0008, 32'h99, 32'h7777_7777, 2, 0, 2);
    idle(1);
    // Core withdraws, slave never answers: bridge times out silently.
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h3000_0000;
    @(negedge clk);
    req_i = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk("wd_valid", m_valid_o, i <= TO);
      chk("wd_hold", hold_o, i <= TO);
      chk("wd_err", err_o, 0);
      chk("wd_rdata", rdata_o, 0);
      @(negedge clk);
    end
    // Core withdraws, slave answers: no DONE, data not presented.
    req_i = 1'b1; addr_i = 32'h3000_0010; m_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    m_ready_i = 1'b1; m_rvalid_i = 1'b1;
    #1 chk("wd2_hold", hold_o, 1);
    @(negedge clk);
    m_ready_i = 1'b0; m_rvalid_i = 1'b0;
    #1;
    chk("wd2_rdata", rdata_o, 0);
    chk("wd2_err", err_o, 0);
    chk("wd2_valid", m_valid_o, 0);
    idle(1);
    // Reset while waiting in RESP.
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h4000_0040; wdata_i = 32'hA5A5_A5A5;
    @(negedge clk);
    m_ready_i = 1'b1;
    @(negedge clk);
    m_ready_i = 1'b0;
    #1;
    chk("resp_hold", hold_o, 1);
    chk("resp_valid", m_valid_o, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_addr", m_addr_o, 0);
    chk("arst_wdata", m_wdata_o, 0);
    chk("arst_we", m_we_o, 0);
    chk("arst_valid", m_valid_o, 0);
    req_i = 1'b0;
    #1 chk("arst_hold", hold_o, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    xfer(1'b0, 32'h4000_0044, 32'h0, 32'h0BAD_CAFE, 1, 1, 0);
    for (int n = 0; n < 25; n++) begin
      dr = $urandom_range(0, 3);
      dv = $urandom_range(0, 3);
      md = $urandom_range(0, 5) == 0 ? $urandom_range(1, 2) : 0;
      xfer(1'($urandom), $urandom, $urandom, $urandom, dr, dv, md);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
